// File: rtl/fb_access_arbiter_if.sv
// rtl/fb_access_arbiter_if.sv - display, CPU and RAM port bundle of the frame-buffer arbiter
//
// Signal groups:
//   display : disp_req, disp_addr -> disp_data, disp_valid, disp_miss
//   cpu     : cpu_req, cpu_we, cpu_addr, cpu_wdata -> cpu_ack, cpu_rdata,
//             cpu_rvalid, cpu_starved
//   ram     : mem_addr, mem_we, mem_wdata -> mem_rdata
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding system (requesters plus the RAM)
interface fb_access_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              disp_miss;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_starved;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr,
        output disp_data, disp_valid, disp_miss,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_rvalid, cpu_starved,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_data, disp_valid, disp_miss,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid, cpu_starved,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - single-port frame-buffer RAM arbiter, display priority over CPU
//
// Ports:
//   vga_clk : single clock for all logic
//   rst     : synchronous, active-high reset
//   bus     : fb_access_arbiter_if.slave (display stream, CPU req/ack port, RAM port)
// Optional feature:
//   FB_STARVE_STEAL_EN - when defined, a starved CPU takes one slot from the display
//                        (disp_miss pulses); when undefined the display always wins.
// Pipeline: request sampled at edge N, RAM controls in N+1, RAM data in N+2,
// routed read data valid in N+3.
module fb_access_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 90624,
    parameter int STARVE_LIMIT = 640
) (
    input  logic                vga_clk,
    input  logic                rst,
    fb_access_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_CPU} grant_t;

    grant_t            grant_q;     // owner of the RAM slot currently driven on mem_*
    grant_t            grant_d;
    logic              cpu_rd_s1;   // the CPU slot on mem_* is a read
    logic              oor_s1;      // address on mem_* is out of range
    grant_t            owner_s2;    // owner of the word on mem_rdata
    logic              oor_s2;
    logic [CNT_W-1:0]  starve_cnt;

    logic cpu_elig;
    logic starve_hit;
    logic steal;
    logic disp_oor;
    logic cpu_oor;

    always_comb begin
        // The ack cycle itself is never eligible, so back-to-back CPU grants are impossible.
        cpu_elig   = bus.cpu_req && !bus.cpu_ack;
        starve_hit = (starve_cnt == LIMIT);
        disp_oor   = ({1'b0, bus.disp_addr} >= DEPTH_L);
        cpu_oor    = ({1'b0, bus.cpu_addr} >= DEPTH_L);
`ifdef FB_STARVE_STEAL_EN
        steal      = cpu_elig && bus.disp_req && starve_hit;
`else
        steal      = 1'b0;
`endif
        grant_d = GNT_IDLE;
        if (steal)             grant_d = GNT_CPU;
        else if (bus.disp_req) grant_d = GNT_DISP;
        else if (cpu_elig)     grant_d = GNT_CPU;
    end

    assign bus.cpu_starved = starve_hit;

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            grant_q        <= GNT_IDLE;
            cpu_rd_s1      <= 1'b0;
            oor_s1         <= 1'b0;
            owner_s2       <= GNT_IDLE;
            oor_s2         <= 1'b0;
            starve_cnt     <= '0;
            bus.mem_addr   <= '0;
            bus.mem_we     <= 1'b0;
            bus.mem_wdata  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.disp_miss  <= 1'b0;
            bus.disp_data  <= '0;
            bus.disp_valid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.cpu_rvalid <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            bus.mem_we    <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.disp_miss <= steal;
            cpu_rd_s1     <= 1'b0;
            oor_s1        <= 1'b0;

            // Stage 1: drive the RAM port; mem_addr holds when idle.
            case (grant_d)
                GNT_DISP: begin
                    bus.mem_addr <= bus.disp_addr;
                    oor_s1       <= disp_oor;
                end
                GNT_CPU: begin
                    bus.mem_addr  <= bus.cpu_addr;
                    bus.mem_wdata <= bus.cpu_wdata;
                    bus.mem_we    <= bus.cpu_we && !cpu_oor;
                    bus.cpu_ack   <= 1'b1;
                    cpu_rd_s1     <= !bus.cpu_we;
                    oor_s1        <= cpu_oor;
                end
                default: ;
            endcase

            // Stage 2: CPU writes carry no return word.
            owner_s2 <= (grant_q == GNT_CPU && !cpu_rd_s1) ? GNT_IDLE : grant_q;
            oor_s2   <= oor_s1;

            // Stage 3: route the returning word; out-of-range reads yield zero.
            bus.disp_valid <= (owner_s2 == GNT_DISP);
            bus.cpu_rvalid <= (owner_s2 == GNT_CPU);
            if (owner_s2 == GNT_DISP)
                bus.disp_data <= oor_s2 ? '0 : bus.mem_rdata;
            if (owner_s2 == GNT_CPU)
                bus.cpu_rdata <= oor_s2 ? '0 : bus.mem_rdata;

            // Starvation: count losses to the display, saturate, clear on grant or withdrawal.
            if (!bus.cpu_req || grant_d == GNT_CPU)
                starve_cnt <= '0;
            else if (cpu_elig && grant_d == GNT_DISP && !starve_hit)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - directed self-checking bench for fb_access_arbiter
module tb_fb_access_arbiter;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 vga_clk = ~vga_clk;

    fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(90624), .STARVE_LIMIT(640)
    ) dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // RAM model: valid words preset to addr[7:0], beyond DEPTH preset to 0xEE.
    logic [7:0] ram [0:131071];
    initial begin
        for (int i = 0; i < 131072; i++) ram[i] = (i < 90624) ? i[7:0] : 8'hEE;
    end
    always @(posedge vga_clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.disp_req  = 1'b0;
        bus.disp_addr = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.disp_valid, bus.cpu_rvalid, bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000000",
                     {bus.disp_valid, bus.cpu_rvalid, bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.mem_we});
        end
        vectors++;
        if ({bus.mem_addr, bus.mem_wdata, bus.disp_data, bus.cpu_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses got %h want 0", {bus.mem_addr, bus.mem_wdata, bus.disp_data, bus.cpu_rdata});
        end
    endtask

    task automatic test_display_stream();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            bus.disp_req  = (c < 5);
            bus.disp_addr = ADDR_W'(324 + c);
            vectors++;
            if (bus.disp_valid !== (c >= 3 && c <= 7)) begin
                miscompares++;
                $display("FAIL disp_valid c=%0d got %b", c, bus.disp_valid);
            end
            if (c >= 3 && c <= 7) begin
                vectors++;
                if (bus.disp_data !== 8'(8'h44 + c - 3)) begin
                    miscompares++;
                    $display("FAIL disp_data c=%0d got %h want %h", c, bus.disp_data, 8'(8'h44 + c - 3));
                end
            end
            if (c >= 1 && c <= 5) begin
                vectors++;
                if (bus.mem_addr !== ADDR_W'(324 + c - 1) || bus.mem_we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL disp_mem c=%0d addr %0d we %b want %0d we 0", c, bus.mem_addr, bus.mem_we, 324 + c - 1);
                end
            end
            vectors++;
            if (bus.cpu_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL disp_no_ack c=%0d got %b want 0", c, bus.cpu_ack);
            end
            tick();
        end
    endtask

    // Write then read back; entry 1 is the out-of-range address.
    task automatic test_cpu_rw();
        logic [ADDR_W-1:0] addr_t  [2] = '{17'd1000, 17'd90624};
        logic [7:0]        wdata_t [2] = '{8'hA5, 8'hFF};
        logic              we_t    [2] = '{1'b1, 1'b0};
        logic [7:0]        rd_t    [2] = '{8'hA5, 8'h00};
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 7; c++) begin
                bus.cpu_req   = (c <= 3);
                bus.cpu_we    = (c <= 1);
                bus.cpu_addr  = addr_t[k];
                bus.cpu_wdata = wdata_t[k];
                vectors++;
                if (bus.cpu_ack !== (c == 1 || c == 3)) begin
                    miscompares++;
                    $display("FAIL cpu_ack k=%0d c=%0d got %b", k, c, bus.cpu_ack);
                end
                vectors++;
                if (bus.mem_we !== (c == 1 && we_t[k])) begin
                    miscompares++;
                    $display("FAIL cpu_mem_we k=%0d c=%0d got %b", k, c, bus.mem_we);
                end
                if (c == 1 || c == 3) begin
                    vectors++;
                    if (bus.mem_addr !== addr_t[k]) begin
                        miscompares++;
                        $display("FAIL cpu_mem_addr k=%0d c=%0d got %0d want %0d", k, c, bus.mem_addr, addr_t[k]);
                    end
                end
                vectors++;
                if (bus.cpu_rvalid !== (c == 5)) begin
                    miscompares++;
                    $display("FAIL cpu_rvalid k=%0d c=%0d got %b", k, c, bus.cpu_rvalid);
                end
                if (c == 5) begin
                    vectors++;
                    if (bus.cpu_rdata !== rd_t[k]) begin
                        miscompares++;
                        $display("FAIL cpu_rdata k=%0d got %h want %h", k, bus.cpu_rdata, rd_t[k]);
                    end
                end
                tick();
            end
        end
        idle_inputs();
    endtask

    task automatic test_display_oor();
        for (int c = 0; c < 7; c++) begin
            bus.disp_req  = (c < 2);
            bus.disp_addr = (c == 0) ? 17'd100000 : 17'd7;
            if (c == 3 || c == 4) begin
                vectors++;
                if (bus.disp_valid !== 1'b1 || bus.disp_data !== ((c == 3) ? 8'h00 : 8'h07)) begin
                    miscompares++;
                    $display("FAIL disp_oor c=%0d valid %b data %h want 1 %h", c, bus.disp_valid, bus.disp_data,
                             (c == 3) ? 8'h00 : 8'h07);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        logic steal_en;
`ifdef FB_STARVE_STEAL_EN
        steal_en = 1'b1;
`else
        steal_en = 1'b0;
`endif
        for (int c = 0; c <= 650; c++) begin
            logic e_ack, e_miss, e_starv, e_dv, e_cv;
            bus.disp_addr = 17'd5;
            bus.cpu_we    = 1'b0;
            bus.cpu_addr  = 17'd2000;
            if (steal_en) begin
                bus.disp_req = (c <= 645);
                bus.cpu_req  = (c <= 641);
                e_ack   = (c == 641);
                e_miss  = (c == 641);
                e_starv = (c == 640);
                e_dv    = (c >= 3 && c <= 648 && c != 643);
                e_cv    = (c == 643);
            end else begin
                bus.disp_req = (c <= 645);
                bus.cpu_req  = (c <= 647);
                e_ack   = (c == 647);
                e_miss  = 1'b0;
                e_starv = (c >= 640 && c <= 646);
                e_dv    = (c >= 3 && c <= 648);
                e_cv    = (c == 649);
            end
            vectors++;
            if ({bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.disp_valid, bus.cpu_rvalid} !==
                {e_ack, e_miss, e_starv, e_dv, e_cv}) begin
                miscompares++;
                $display("FAIL starve c=%0d ack/miss/starved/dvalid/rvalid got %b want %b", c,
                         {bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.disp_valid, bus.cpu_rvalid},
                         {e_ack, e_miss, e_starv, e_dv, e_cv});
            end
            if (e_cv) begin
                vectors++;
                if (bus.cpu_rdata !== 8'hD0) begin
                    miscompares++;
                    $display("FAIL starve_rdata got %h want d0", bus.cpu_rdata);
                end
            end
            if (c == 100) begin
                vectors++;
                if (bus.disp_data !== 8'h05) begin
                    miscompares++;
                    $display("FAIL starve_disp_data got %h want 05", bus.disp_data);
                end
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c <= 8; c++) begin
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 17'd20;
            bus.cpu_req  = (c <= 1 || c == 3);
            bus.disp_req = (c >= 1 && c <= 3);
            bus.disp_addr = ADDR_W'(9 + c);
            rst = (c == 3);
            if (c == 3) begin
                vectors++;
                if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 8'h14) begin
                    miscompares++;
                    $display("FAIL inflight_cpu_read got %b %h want 1 14", bus.cpu_rvalid, bus.cpu_rdata);
                end
            end
            if (c == 4) begin
                idle_inputs();
                vectors++;
                if ({bus.disp_valid, bus.cpu_rvalid, bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.mem_we,
                     bus.mem_addr, bus.mem_wdata, bus.disp_data, bus.cpu_rdata} !== '0) begin
                    miscompares++;
                    $display("FAIL post_reset_outputs got %h want 0",
                             {bus.disp_valid, bus.cpu_rvalid, bus.cpu_ack, bus.disp_miss, bus.cpu_starved, bus.mem_we,
                              bus.mem_addr, bus.mem_wdata, bus.disp_data, bus.cpu_rdata});
                end
            end
            if (c >= 4) begin
                idle_inputs();
                vectors++;
                if (bus.disp_valid !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL inflight_valid c=%0d dvalid %b rvalid %b want 0 0", c, bus.disp_valid, bus.cpu_rvalid);
                end
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_display_stream();
        test_cpu_rw();
        test_display_oor();
        test_starvation();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Single-port access arbiter for the grayscale frame-buffer RAM. It shares one synchronous RAM port between two requesters. The display read stream (pixel fetch) has real-time priority. The CPU/loader port uses a req/ack handshake and may read or write. The block registers all RAM control signals, tracks which requester owns each returning read word, and flags or resolves CPU starvation.

## Interface
Parameters:
- ADDR_W, 17, RAM address width
- DATA_W, 8, pixel width
- DEPTH, 90624, number of valid RAM words; addresses >= DEPTH are out of range
- STARVE_LIMIT, 640, consecutive CPU wait cycles that count as starvation

Ports:
- vga_clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- disp_req  in  1  display requests one read this cycle
- disp_addr  in  ADDR_W  display read address
- disp_data  out  DATA_W  display read data
- disp_valid  out  1  disp_data valid this cycle
- disp_miss  out  1  one-cycle pulse: a display request was not served
- cpu_req  in  1  CPU access request; hold high with stable fields until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU access accepted
- cpu_rdata  out  DATA_W  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_starved  out  1  CPU has waited >= STARVE_LIMIT cycles; clears on cpu_ack
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data; one-cycle synchronous read latency

## Operation
- Grant state register: IDLE, DISP or CPU. It is re-evaluated every cycle from the requests sampled at the clock edge.
- Priority: disp_req=1 → DISP; otherwise a pending CPU request → CPU; otherwise IDLE.
- CPU eligibility: cpu_req=1 and cpu_ack=0. The cycle in which cpu_ack is high is never a CPU grant, so the CPU gets at most one access per 2 cycles.
- DISP grant: mem_addr=disp_addr, mem_we=0, and the owner tag pipe records DISP.
- CPU grant:
  - mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, and cpu_ack pulses.
  - For a read, the owner tag records CPU.
  - For a write with cpu_addr >= DEPTH, mem_we is forced to 0 but cpu_ack still pulses.
- IDLE: mem_we=0, mem_addr holds its previous value, and the owner tag records NONE.
- Read return: at the edge where mem_rdata is valid, the tag selects the destination.
  - DISP: disp_data and disp_valid are loaded.
  - CPU: cpu_rdata and cpu_rvalid are loaded.
  - A CPU read of an out-of-range address returns 0. A display read of an out-of-range address also returns 0.
- Starvation counter:
  - Increments each cycle an eligible CPU request loses to the display.
  - Saturates at STARVE_LIMIT.
  - Clears on cpu_ack or when cpu_req=0.
  - cpu_starved = (counter == STARVE_LIMIT).
- Outputs that carry nothing in a given cycle: disp_valid, cpu_rvalid, cpu_ack and disp_miss are 0 in every cycle with no corresponding event.

## Timing
- Reset: every output is 0, grant is IDLE, the counter is 0, and the owner tag pipe is cleared.
  - Reads in flight when rst asserts never produce a valid after reset.
  - rst held for 1 cycle is sufficient.
- A request presented in cycle N is sampled at the end of cycle N.
  - mem_* and cpu_ack are driven in cycle N+1.
  - The RAM returns data in cycle N+2.
  - disp_valid/disp_data or cpu_rvalid/cpu_rdata are valid in cycle N+3.
- Display throughput: one read per cycle, fully pipelined.
- Simultaneous disp_req and eligible cpu_req: the display wins, unless the starvation override applies (see Configuration).
- A CPU write is complete from the RAM's point of view at the end of cycle N+1. A CPU read issued after that write returns the new value.
- Dropping cpu_req before ack cancels the request without side effects. The counter clears.

## Configuration
- FB_STARVE_STEAL_EN defined: when the counter reaches STARVE_LIMIT and disp_req=1, the CPU wins that single slot.
  - disp_miss pulses in the cycle the stolen display request would have been driven (N+1).
  - No disp_valid is produced for that request.
  - The counter clears with cpu_ack.
- FB_STARVE_STEAL_EN undefined: the display always wins and disp_miss is tied to 0.
  - cpu_starved stays high until the CPU is granted in a display gap.

## Test plan
- Reset, then disp_req=1 for 5 cycles with addresses 324..328 and RAM data = addr[7:0] → disp_valid high in cycles 3..7 with disp_data 0x44..0x48, and no cpu_ack.
- disp_req=0, CPU write to addr 1000 with data 0xA5, then a CPU read of addr 1000 → cpu_ack 1 cycle after each request, mem_we=1 only for the write, and cpu_rvalid with 0xA5 3 cycles after the read request.
- CPU write to addr 90624 with data 0xFF → cpu_ack pulses, mem_we stays 0, and a following read of addr 90624 returns 0x00.
- disp_req held high and cpu_req high for 640 cycles:
  - cpu_starved rises at cycle 640.
  - With FB_STARVE_STEAL_EN, the CPU is acked in the next slot and disp_miss pulses once.
  - Without the macro, no ack occurs until disp_req drops.
- Both requesters active with 2 display reads in flight, then rst asserted for 1 cycle → all outputs 0 the cycle after reset, and no disp_valid or cpu_rvalid follows from the in-flight reads.
